// File: rtl/nx_ia_arb_pkg.sv
// Purpose : shared types and constants for the indirect-access memory arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: read-return tag struct, port-id width helper, legal RD_LATENCY range.
package nx_ia_arb_pkg;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // Tags carry a fixed-width port id sized for the largest legal port count,
    // so one struct type serves every N_HW_PORTS configuration.
    localparam int MAX_HW_PORTS = 8;
    localparam int TAG_ID_W     = 3;

    typedef struct packed {
        logic                valid;
        logic                is_sw;
        logic [TAG_ID_W-1:0] id;
    } arb_tag_t;

    // Width of an index into n ports; never zero so a single port still
    // gets a real (constant) pointer register.
    function automatic int port_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Purpose : N-way round-robin arbiter with rotating pointer and a lock override.
// Latency : grant is combinational from req; pointer advances on the clock after a grant.
// Backpressure: requesters hold req until granted; lock=1 withholds every grant and freezes the pointer.
//
// Ports: clk, rst_n, req[N] (requests), lock (suppress all grants), gnt[N] (one-hot grant).
module nx_rr_arbiter
    import nx_ia_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         lock,
    output logic [N-1:0] gnt
);

    localparam int PW = port_id_width(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] cand;
    logic [PW-1:0] win_idx;
    logic          found;

    // Search upward from the pointer, wrapping; the first asserted request wins.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int off = 0; off < N; off++) begin
            cand = PW'((int'(ptr_q) + off) % N);
            if (!found && !lock && req[cand]) begin
                gnt[cand] = 1'b1;
                found     = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The pointer moves only when a grant is actually issued, so a locked
    // cycle leaves the rotation exactly where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/nx_ia_mem_arbiter.sv
// Purpose : shares one single-port memory between N hardware requesters and the software indirect-access port.
// Latency : command registered onto mem_* 1 cycle after grant; read data returns 1+RD_LATENCY cycles after grant.
// Backpressure: losers hold their request until granted; software is lowest priority until yield, then absolute.
//
// Ports: sw_* / yield / grant / rsp / sw_rdat  - software indirect-access side
//        hw_req/hw_we/hw_add/hw_wdat/hw_gnt/hw_rvalid/hw_rdat - hardware datapath side (flat packed per port)
//        mem_cs/mem_we/mem_add/mem_wdat/mem_rdat - memory pins
//        sw_stall_cnt / stat_clr - software lost-arbitration counter
// Build option: define NX_IA_ARB_STATS_EN to build the stall counter; otherwise sw_stall_cnt is tied to 0.
module nx_ia_mem_arbiter
    import nx_ia_arb_pkg::*;
#(
    parameter  int N_HW_PORTS  = 2,
    parameter  int N_ENTRIES   = 1024,
    parameter  int N_DATA_BITS = 32,
    parameter  int RD_LATENCY  = 1,
    localparam int AW          = $clog2(N_ENTRIES),
    localparam int DW          = N_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // software indirect-access port
    input  logic                     sw_cs,
    input  logic                     sw_we,
    input  logic [AW-1:0]            sw_add,
    input  logic [DW-1:0]            sw_wdat,
    input  logic                     yield,
    output logic                     grant,
    output logic                     rsp,
    output logic [DW-1:0]            sw_rdat,
    // hardware requesters
    input  logic [N_HW_PORTS-1:0]    hw_req,
    input  logic [N_HW_PORTS-1:0]    hw_we,
    input  logic [N_HW_PORTS*AW-1:0] hw_add,
    input  logic [N_HW_PORTS*DW-1:0] hw_wdat,
    output logic [N_HW_PORTS-1:0]    hw_gnt,
    output logic [N_HW_PORTS-1:0]    hw_rvalid,
    output logic [DW-1:0]            hw_rdat,
    // memory pins
    output logic                     mem_cs,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_add,
    output logic [DW-1:0]            mem_wdat,
    input  logic [DW-1:0]            mem_rdat,
    // statistics
    output logic [15:0]              sw_stall_cnt,
    input  logic                     stat_clr
);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("nx_ia_mem_arbiter: RD_LATENCY out of range");
    end
    if (N_HW_PORTS < 1 || N_HW_PORTS > MAX_HW_PORTS) begin : g_bad_ports
        $error("nx_ia_mem_arbiter: N_HW_PORTS out of range");
    end

    localparam int DEPTH = RD_LATENCY + 1;

    logic                sw_win;
    logic                sw_lock;
    logic                any_gnt;
    logic                win_we;
    logic [AW-1:0]       win_add;
    logic [DW-1:0]       win_wdat;
    logic [TAG_ID_W-1:0] win_id;
    arb_tag_t            push_tag;
    arb_tag_t            pop_tag;
    arb_tag_t            tag_q [DEPTH];

    // Software takes the cycle when it has yielded-priority, or when no
    // hardware port is asking. The lock keeps the hardware arbiter quiet (and
    // its pointer frozen) during a yield win.
    assign sw_lock = sw_cs & yield;
    assign sw_win  = sw_cs & (yield | ~(|hw_req));
    assign grant   = sw_win;

    nx_rr_arbiter #(
        .N (N_HW_PORTS)
    ) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (hw_req),
        .lock  (sw_lock),
        .gnt   (hw_gnt)
    );

    assign any_gnt = sw_win | (|hw_gnt);

    // Winner operand select; hw_gnt is one-hot so at most one port matches.
    always_comb begin
        win_we   = sw_we;
        win_add  = sw_add;
        win_wdat = sw_wdat;
        win_id   = '0;
        if (!sw_win) begin
            win_we   = 1'b0;
            win_add  = '0;
            win_wdat = '0;
            for (int i = 0; i < N_HW_PORTS; i++) begin
                if (hw_gnt[i]) begin
                    win_we   = hw_we[i];
                    win_add  = hw_add[i*AW +: AW];
                    win_wdat = hw_wdat[i*DW +: DW];
                    win_id   = TAG_ID_W'(i);
                end
            end
        end
    end

    // Command register: address/data hold when idle, cs/we drop to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_add  <= '0;
            mem_wdat <= '0;
        end else if (any_gnt) begin
            mem_cs   <= 1'b1;
            mem_we   <= win_we;
            mem_add  <= win_add;
            mem_wdat <= win_wdat;
        end else begin
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
        end
    end

    // Tag pipeline: stage k holds the tag of the grant issued k+1 cycles ago,
    // so the last stage lines up with mem_rdat for that read.
    always_comb begin
        push_tag       = '0;
        push_tag.valid = any_gnt & ~win_we;
        push_tag.is_sw = sw_win;
        push_tag.id    = win_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= push_tag;
            for (int k = 1; k < DEPTH; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign pop_tag = tag_q[DEPTH-1];

    // Return steering: data buses are zero except in the pulse cycle.
    always_comb begin
        rsp       = pop_tag.valid & pop_tag.is_sw;
        sw_rdat   = rsp ? mem_rdat : '0;
        hw_rvalid = '0;
        hw_rdat   = '0;
        if (pop_tag.valid && !pop_tag.is_sw) begin
            hw_rdat = mem_rdat;
            for (int i = 0; i < N_HW_PORTS; i++) begin
                hw_rvalid[i] = (pop_tag.id == TAG_ID_W'(i));
            end
        end
    end

`ifdef NX_IA_ARB_STATS_EN
    logic [15:0] stall_q;

    // Counts every cycle software is asking but not granted; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stat_clr) begin
            stall_q <= '0;
        end else if (sw_cs && !grant && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign sw_stall_cnt = stall_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign sw_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_nx_ia_mem_arbiter.sv
module tb_nx_ia_mem_arbiter;

    localparam int N   = 2;
    localparam int ENT = 1024;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int L   = 2;

`ifdef NX_IA_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            sw_cs, sw_we, yield, grant, rsp, stat_clr;
    logic [AW-1:0]   sw_add;
    logic [DW-1:0]   sw_wdat, sw_rdat, hw_rdat;
    logic [N-1:0]    hw_req, hw_we, hw_gnt, hw_rvalid;
    logic [N*AW-1:0] hw_add;
    logic [N*DW-1:0] hw_wdat;
    logic            mem_cs, mem_we;
    logic [AW-1:0]   mem_add;
    logic [DW-1:0]   mem_wdat, mem_rdat;
    logic [15:0]     sw_stall_cnt;

    nx_ia_mem_arbiter #(
        .N_HW_PORTS  (N),
        .N_ENTRIES   (ENT),
        .N_DATA_BITS (DW),
        .RD_LATENCY  (L)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_cs        (sw_cs),
        .sw_we        (sw_we),
        .sw_add       (sw_add),
        .sw_wdat      (sw_wdat),
        .yield        (yield),
        .grant        (grant),
        .rsp          (rsp),
        .sw_rdat      (sw_rdat),
        .hw_req       (hw_req),
        .hw_we        (hw_we),
        .hw_add       (hw_add),
        .hw_wdat      (hw_wdat),
        .hw_gnt       (hw_gnt),
        .hw_rvalid    (hw_rvalid),
        .hw_rdat      (hw_rdat),
        .mem_cs       (mem_cs),
        .mem_we       (mem_we),
        .mem_add      (mem_add),
        .mem_wdat     (mem_wdat),
        .mem_rdat     (mem_rdat),
        .sw_stall_cnt (sw_stall_cnt),
        .stat_clr     (stat_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data valid L cycles after mem_cs is seen.
    logic          load_en;
    logic [DW-1:0] mem [ENT];
    logic [DW-1:0] rd_pipe [L];

    always @(posedge clk) begin
        if (load_en) begin
            mem[3]  <= 32'hA5A5_A5A5;
            mem[16] <= 32'h1010_CAFE;
            mem[17] <= 32'h1111_BEEF;
        end else if (mem_cs && mem_we) begin
            mem[mem_add] <= mem_wdat;
        end
        rd_pipe[0] <= mem[mem_add];
        for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdat = rd_pipe[L-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic          is_sw;
        int            port;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;

    task automatic push(input logic is_sw, input int port, input logic [DW-1:0] data);
        exp_t e;
        e.is_sw = is_sw;
        e.port  = port;
        e.data  = data;
        e.cyc   = cyc + 1 + L;
        sb.push_back(e);
    endtask

    // Scoreboard: every return pulse must match the oldest expected read,
    // including the exact cycle it was due.
    always @(negedge clk) begin
        if (rst_n && (rsp || (hw_rvalid != '0))) begin
            if (sb.size() == 0) begin
                chk("unexpected_ret", 64'({rsp, hw_rvalid}), 64'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("ret_rsp", 64'(rsp), 64'(mon_e.is_sw));
                chk("ret_hw_rvalid", 64'(hw_rvalid), mon_e.is_sw ? 64'h0 : (64'h1 << mon_e.port));
                chk("ret_data", 64'(mon_e.is_sw ? sw_rdat : hw_rdat), 64'(mon_e.data));
                chk("ret_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic idle();
        sw_cs = 0; sw_we = 0; sw_add = '0; sw_wdat = '0; yield = 0;
        hw_req = '0; hw_we = '0; hw_add = '0; hw_wdat = '0; stat_clr = 0;
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "_mem_cs"},    64'(mem_cs), 64'h0);
        chk({p, "_mem_we"},    64'(mem_we), 64'h0);
        chk({p, "_mem_add"},   64'(mem_add), 64'h0);
        chk({p, "_mem_wdat"},  64'(mem_wdat), 64'h0);
        chk({p, "_rsp"},       64'(rsp), 64'h0);
        chk({p, "_sw_rdat"},   64'(sw_rdat), 64'h0);
        chk({p, "_hw_rvalid"}, 64'(hw_rvalid), 64'h0);
        chk({p, "_hw_rdat"},   64'(hw_rdat), 64'h0);
        chk({p, "_stall"},     64'(sw_stall_cnt), 64'h0);
    endtask

    initial begin
        rst_n = 0;
        load_en = 1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_reset_outputs("rst");
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_hw_gnt", 64'(hw_gnt), 64'h0);
        load_en = 0;
        rst_n = 1;

        // Round-robin with both ports writing continuously.
        hw_we   = 2'b11;
        hw_add  = {10'h21, 10'h20};
        hw_wdat = {32'h2222_0001, 32'h1111_0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hw_req = 2'b11;
            #1;
            chk("rr_gnt", 64'(hw_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
            chk("rr_sw_grant", 64'(grant), 64'h0);
            if (i > 0) chk("rr_mem_add", 64'(mem_add), (i % 2 == 1) ? 64'h20 : 64'h21);
        end
        @(negedge clk);
        idle();
        #1;
        chk("rr_mem_cs", 64'(mem_cs), 64'h1);
        chk("rr_mem_we", 64'(mem_we), 64'h1);
        chk("rr_mem_add_last", 64'(mem_add), 64'h21);
        chk("rr_mem_wdat", 64'(mem_wdat), 64'h2222_0001);

        // Hardware read from port 1.
        @(negedge clk);
        hw_req = 2'b10; hw_we = 2'b00; hw_add = {10'h3, 10'h0};
        #1;
        chk("hwrd_gnt", 64'(hw_gnt), 64'h2);
        chk("hwrd_idle_cs", 64'(mem_cs), 64'h0);
        push(1'b0, 1, 32'hA5A5_A5A5);
        @(negedge clk);
        idle();
        #1;
        chk("hwrd_mem_cs", 64'(mem_cs), 64'h1);
        chk("hwrd_mem_we", 64'(mem_we), 64'h0);
        chk("hwrd_mem_add", 64'(mem_add), 64'h3);
        repeat (4) @(negedge clk);
        #1;
        chk("hwrd_drain", 64'(sb.size()), 64'h0);

        // Software loses to hardware for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sw_cs = 1; sw_we = 0; sw_add = 10'h10;
            hw_req = 2'b01; hw_we = 2'b01; hw_add = {10'h0, 10'h30}; hw_wdat = {32'h0, 32'h77};
            #1;
            chk("swlow_grant", 64'(grant), 64'h0);
            chk("swlow_hw_gnt", 64'(hw_gnt), 64'h1);
        end
        @(negedge clk);
        hw_req = 2'b00;
        #1;
        chk("swlow_grant_free", 64'(grant), 64'h1);
        chk("swlow_hw_gnt_free", 64'(hw_gnt), 64'h0);
        chk("swlow_stall3", 64'(sw_stall_cnt), STATS ? 64'd3 : 64'd0);
        push(1'b1, 0, 32'h1010_CAFE);
        // Clear must beat a simultaneous loss.
        @(negedge clk);
        hw_req = 2'b01; stat_clr = 1;
        #1;
        chk("clr_grant", 64'(grant), 64'h0);
        chk("clr_stall_hold", 64'(sw_stall_cnt), STATS ? 64'd3 : 64'd0);
        @(negedge clk);
        stat_clr = 0;
        #1;
        chk("clr_stall_zero", 64'(sw_stall_cnt), 64'd0);
        @(negedge clk);
        idle();
        #1;
        chk("clr_stall_one", 64'(sw_stall_cnt), STATS ? 64'd1 : 64'd0);

        // Yield: software beats both hardware ports; pointer (now 1) is kept.
        @(negedge clk);
        yield = 1; sw_cs = 1; sw_we = 1; sw_add = 10'h40; sw_wdat = 32'hDEAD_BEEF;
        hw_req = 2'b11; hw_we = 2'b11; hw_add = {10'h21, 10'h20};
        #1;
        chk("yield_grant", 64'(grant), 64'h1);
        chk("yield_hw_gnt", 64'(hw_gnt), 64'h0);
        @(negedge clk);
        yield = 0; sw_cs = 0;
        #1;
        chk("yield_ptr_kept", 64'(hw_gnt), 64'h2);
        chk("yield_mem_add", 64'(mem_add), 64'h40);
        chk("yield_mem_wdat", 64'(mem_wdat), 64'hDEAD_BEEF);
        chk("yield_mem_we", 64'(mem_we), 64'h1);
        @(negedge clk);
        idle();

        // Back-to-back mixed reads.
        @(negedge clk);
        sw_cs = 1; sw_we = 0; sw_add = 10'h10;
        #1;
        chk("b2b_sw_grant", 64'(grant), 64'h1);
        push(1'b1, 0, 32'h1010_CAFE);
        @(negedge clk);
        sw_cs = 0; hw_req = 2'b01; hw_we = 2'b00; hw_add = {10'h0, 10'h11};
        #1;
        chk("b2b_hw_gnt", 64'(hw_gnt), 64'h1);
        push(1'b0, 0, 32'h1111_BEEF);
        @(negedge clk);
        hw_req = 2'b00; sw_cs = 1; sw_add = 10'h40;
        #1;
        chk("b2b_sw_grant2", 64'(grant), 64'h1);
        push(1'b1, 0, 32'hDEAD_BEEF);
        @(negedge clk);
        idle();
        repeat (5) @(negedge clk);
        #1;
        chk("b2b_drain", 64'(sb.size()), 64'h0);

        // Reset with two reads in flight; pointer left at 1 beforehand.
        @(negedge clk);
        sw_cs = 1; sw_we = 0; sw_add = 10'h10;
        #1;
        chk("mid_sw_grant", 64'(grant), 64'h1);
        @(negedge clk);
        sw_cs = 0; hw_req = 2'b01; hw_we = 2'b00; hw_add = {10'h0, 10'h11};
        #1;
        chk("mid_hw_gnt", 64'(hw_gnt), 64'h1);
        @(negedge clk);
        idle();
        #1;
        rst_n = 0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_ret", 64'({rsp, hw_rvalid}), 64'h0);
        end
        @(negedge clk);
        hw_req = 2'b11; hw_we = 2'b11; hw_add = {10'h21, 10'h20};
        #1;
        chk("post_rst_ptr", 64'(hw_gnt), 64'h1);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        #1;
        chk("final_drain", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nx_ia_mem_arbiter.md
# nx_ia_mem_arbiter

Shares one single-port memory between N hardware datapath requesters and the software indirect-access port. The software port is the sw_cs/sw_we/sw_add/sw_wdat/yield/grant/rsp interface of the indirect-access controller. The block arbitrates round-robin among hardware ports and gives software low priority until the controller raises yield, after which software has absolute priority. It registers the winning command onto the memory pins and routes read data back to the issuer through a tagged latency pipeline.

## Interface
- N_HW_PORTS, 2: number of hardware requesters (1..8).
- N_ENTRIES, 1024: memory depth; address width is `$clog2(N_ENTRIES)`.
- N_DATA_BITS, 32: memory word width.
- RD_LATENCY, 1: cycles from mem_cs high at the memory to mem_rdat valid (1..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- sw_cs  in  1  software access request, held each cycle of a DO_* state.
- sw_we  in  1  software write (1) or read (0).
- sw_add  in  log2(N_ENTRIES)  software address.
- sw_wdat  in  N_DATA_BITS  software write data.
- yield  in  1  software starvation flag; raises software priority.
- grant  out  1  software access accepted this cycle (combinational).
- rsp  out  1  software read data valid on sw_rdat.
- sw_rdat  out  N_DATA_BITS  read data returned to software.
- hw_req  in  N_HW_PORTS  hardware request per port.
- hw_we  in  N_HW_PORTS  hardware write enable per port.
- hw_add  in  N_HW_PORTS × log2(N_ENTRIES)  hardware addresses.
- hw_wdat  in  N_HW_PORTS × N_DATA_BITS  hardware write data.
- hw_gnt  out  N_HW_PORTS  one-hot hardware grant (combinational).
- hw_rvalid  out  N_HW_PORTS  one-hot read-data valid per port.
- hw_rdat  out  N_DATA_BITS  read data, shared by all hardware ports.
- mem_cs  out  1  registered memory chip select.
- mem_we  out  1  registered memory write enable.
- mem_add  out  log2(N_ENTRIES)  registered memory address.
- mem_wdat  out  N_DATA_BITS  registered memory write data.
- mem_rdat  in  N_DATA_BITS  memory read data.
- sw_stall_cnt  out  16  software lost-arbitration count (feature-dependent, see Configuration).
- stat_clr  in  1  clears sw_stall_cnt.

## Operation
- At most one grant per cycle. grant and hw_gnt are mutually exclusive and are decoded combinationally from the current requests.
- Priority order:
  - yield=1 and sw_cs=1: software wins.
  - Otherwise: round-robin among asserted hw_req, searching upward from rr_ptr.
  - Software wins only when no hw_req is asserted.
- rr_ptr updates only on a hardware grant, to (granted index + 1) mod N_HW_PORTS.
- Winner's we/add/wdat are registered onto mem_*; mem_cs=1 in the cycle after the grant.
- Each read issue pushes a tag {valid, is_sw, port id} into a shift pipeline of depth 1+RD_LATENCY. Writes push an invalid tag.
- On tag pop:
  - is_sw=1: rsp=1 and sw_rdat=mem_rdat.
  - is_sw=0: hw_rvalid[id]=1 and hw_rdat=mem_rdat.
  - rsp and hw_rvalid are single-cycle pulses.
- Reads are fully pipelined; a new grant may issue every cycle regardless of reads in flight.
- Memory addresses are not bounds-checked; the requesters (and the controller's NXM check) own range checking.

## Timing
- Reset values: mem_cs=0, mem_we=0, mem_add=0, mem_wdat=0, rsp=0, sw_rdat=0, hw_rvalid=0, hw_rdat=0, rr_ptr=0, all pipeline tags invalid, sw_stall_cnt=0.
- Read latency from grant to rsp/hw_rvalid is 1+RD_LATENCY cycles. Write completes at mem_cs, one cycle after grant.
- sw_cs=0 forces grant=0. hw_req[i]=0 forces hw_gnt[i]=0.
- A requester must hold its request and operands stable until granted.
- Simultaneous sw_cs and hw_req with yield=0: hardware wins, and the software loss increments the stall count.
- yield rising in the same cycle as competing hw_req: software wins in that same cycle.
- Assertion of rst_n mid-operation discards in-flight tags; no rsp or hw_rvalid is produced for them.
- rr_ptr wraps from N_HW_PORTS-1 to 0.

## Configuration
- NX_IA_ARB_STATS_EN defined:
  - sw_stall_cnt increments each cycle with sw_cs=1 and grant=0, saturating at 16'hFFFF.
  - stat_clr=1 loads 0 and takes precedence over increment.
- NX_IA_ARB_STATS_EN undefined:
  - sw_stall_cnt is tied to 0 and stat_clr is ignored.
  - No counter flops are generated.

## Structure
- Package nx_ia_arb_pkg holds:
  - the tag struct (valid, is_sw, port id);
  - the port-id width function;
  - the RD_LATENCY legal-range constants.
- Sub-module nx_rr_arbiter: an N-way round-robin grant with pointer register and a lock input used to override on yield. The top level instantiates it once for the hardware ports.
- Top level contains the priority override, command register, tag pipeline and stats counter.

## Test plan
- **HW round-robin:** N_HW_PORTS=2, hw_req=2'b11 held for 4 cycles -> hw_gnt sequence 01,10,01,10.
- **HW read return:** hw_req[1] reads address 0x3 holding 0xA5A5A5A5, RD_LATENCY=2 -> hw_rvalid=2'b10 with hw_rdat=0xA5A5A5A5 exactly 3 cycles after grant.
- **SW low priority:** sw_cs=1 (read) with hw_req[0]=1 and yield=0 for 3 cycles -> grant=0 for 3 cycles and sw_stall_cnt=3 (stats enabled); grant=1 after hw_req drops.
- **Yield override:** yield=1, sw_cs=1, hw_req=2'b11 -> grant=1 and hw_gnt=0 in that cycle; rr_ptr unchanged.
- **Back-to-back mixed reads:** SW read 0x10, then HW0 read 0x11 on consecutive cycles -> rsp then hw_rvalid[0] on consecutive cycles, each with correct data.
- **Reset mid-read:** assert rst_n low with 2 reads in flight -> no rsp/hw_rvalid after release; all outputs at reset values.
